// File: rtl/fsm_launch_ctrl_if.sv
// Bundle of request, status and sequencer signals for fsm_launch_ctrl.
//   slave  : seen from the launcher (takes req/abort/clr_err and the sequencer's
//            done/state_in, drives start and the status/counter outputs)
//   master : seen from the requester / test environment (the reverse)
interface fsm_launch_ctrl_if #(
  parameter int PEND_W = 3,
  parameter int RUN_W  = 8
);
  logic              req;
  logic              abort;
  logic              clr_err;
  logic              done;
  logic [1:0]        state_in;
  logic              start;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              err_timeout;
  logic              err_seq;
  logic              ovf;

  modport slave (
    input  req, abort, clr_err, done, state_in,
    output start, busy, pend_cnt, run_cnt, err_timeout, err_seq, ovf
  );

  modport master (
    output req, abort, clr_err, done, state_in,
    input  start, busy, pend_cnt, run_cnt, err_timeout, err_seq, ovf
  );
endinterface

// File: rtl/fsm_launch_ctrl.sv
// Launcher for the 4-phase sequencer. Queues single-cycle run requests,
// holds the sequencer's level-sensitive start until done or a timeout, then
// forces a low gap so the sequencer's counter clears. Watches the sequencer
// state for backward steps and keeps run / error bookkeeping for software.
//
// Ports:
//   clk    : clock, rising edge
//   n_rst  : synchronous active-low reset
//   bus    : fsm_launch_ctrl_if.slave
//     req, abort, clr_err     : request / flush / sticky-error clear
//     done, state_in          : sequencer status
//     start, busy             : sequencer start (registered), RUN-or-GAP
//     pend_cnt, run_cnt       : queued requests, completed runs (wrapping)
//     err_timeout, err_seq, ovf : sticky error flags
module fsm_launch_ctrl #(
  parameter int PEND_W  = 3,
  parameter int TIMEOUT = 32,
  parameter int TMR_W   = 6,
  parameter int GAP_CYC = 2,
  parameter int RUN_W   = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  fsm_launch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t            state, state_nxt;
  logic              start_q;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [1:0]        prev_state, prev_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic              err_timeout, err_seq, ovf;
  logic              launch;
  logic              eto_set, eseq_set, ovf_set;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    tmr_nxt   = tmr;
    gap_nxt   = gap_cnt;
    prev_nxt  = prev_state;
    run_nxt   = run_cnt;
    launch    = 1'b0;
    eto_set   = 1'b0;
    eseq_set  = 1'b0;
    ovf_set   = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.abort && (pend != '0 || bus.req)) begin
          launch    = 1'b1;
          state_nxt = RUN;
          tmr_nxt   = '0;
          prev_nxt  = '0;
        end
      end

      RUN: begin
        tmr_nxt  = tmr + 1'b1;
        prev_nxt = bus.state_in;
        // The sequencer only ever moves forward while start is held.
        if (bus.state_in < prev_state) eseq_set = 1'b1;

        if (bus.abort) begin
          state_nxt = GAP;
          gap_nxt   = '0;
        end else if (bus.done) begin
          state_nxt = GAP;
          gap_nxt   = '0;
          run_nxt   = run_cnt + 1'b1;
        end else if (tmr == TMR_LAST) begin
          state_nxt = GAP;
          gap_nxt   = '0;
          eto_set   = 1'b1;
        end
      end

      GAP: begin
        gap_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    // Request queue. Abort discards the queue and any same-cycle request.
    // A launch frees a slot in the same cycle, so a full queue only drops
    // a request when nothing launches.
    if (bus.abort) begin
      pend_nxt = '0;
    end else if (bus.req && !launch && pend == PEND_MAX) begin
      ovf_set = 1'b1;
    end else begin
      pend_nxt = pend + {{(PEND_W-1){1'b0}}, bus.req}
                      - {{(PEND_W-1){1'b0}}, launch};
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      pend        <= '0;
      tmr         <= '0;
      gap_cnt     <= '0;
      prev_state  <= '0;
      run_cnt     <= '0;
      err_timeout <= 1'b0;
      err_seq     <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_q     <= (state_nxt == RUN);
      pend        <= pend_nxt;
      tmr         <= tmr_nxt;
      gap_cnt     <= gap_nxt;
      prev_state  <= prev_nxt;
      run_cnt     <= run_nxt;
      // A set event in the same cycle as clr_err wins.
      err_timeout <= eto_set  | (err_timeout & ~bus.clr_err);
      err_seq     <= eseq_set | (err_seq     & ~bus.clr_err);
      ovf         <= ovf_set  | (ovf         & ~bus.clr_err);
    end
  end

  assign bus.start       = start_q;
  assign bus.busy        = (state != IDLE);
  assign bus.pend_cnt    = pend;
  assign bus.run_cnt     = run_cnt;
  assign bus.err_timeout = err_timeout;
  assign bus.err_seq     = err_seq;
  assign bus.ovf         = ovf;

endmodule

// File: tb/tb_fsm_launch_ctrl.sv
module tb_fsm_launch_ctrl;
  localparam int PEND_W  = 3;
  localparam int TIMEOUT = 32;
  localparam int TMR_W   = 6;
  localparam int GAP_CYC = 2;
  localparam int RUN_W   = 8;
  localparam int PMAX    = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fsm_launch_ctrl_if #(.PEND_W(PEND_W), .RUN_W(RUN_W)) bus();

  fsm_launch_ctrl #(
    .PEND_W(PEND_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W),
    .GAP_CYC(GAP_CYC), .RUN_W(RUN_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sequencer stand-in: counts cycles of start high, done rises in the
  // 14th high cycle, state walks IDLE,S0,S1,S2; everything clears when
  // start is seen low.
  int         seq_cnt;
  logic       seq_done;
  logic [1:0] seq_state;
  logic       done_tie0 = 1'b0;
  logic       st_ovr_en = 1'b0;
  logic [1:0] st_ovr    = 2'd0;

  always @(posedge clk) begin
    if (!n_rst || !bus.start) begin
      seq_cnt   <= 0;
      seq_done  <= 1'b0;
      seq_state <= 2'd0;
    end else begin
      seq_cnt   <= seq_cnt + 1;
      seq_done  <= (seq_cnt + 1 >= 13);
      seq_state <= (seq_cnt + 1 < 5) ? 2'd1 : (seq_cnt + 1 < 9) ? 2'd2 : 2'd3;
    end
  end

  assign bus.done     = done_tie0 ? 1'b0 : seq_done;
  assign bus.state_in = st_ovr_en ? st_ovr : seq_state;

  // Behavioural model: m_age = which high cycle of start we are in (0 when
  // start is low), m_gap = low cycles still owed after a run.
  int m_age, m_gap, m_pend, m_runs, m_prev;
  bit m_eto, m_eseq, m_ovf;

  always @(posedge clk) begin
    bit launch, set_to, set_seq, set_ovf;
    int p;
    launch = 0; set_to = 0; set_seq = 0; set_ovf = 0;
    if (!n_rst) begin
      m_age = 0; m_gap = 0; m_pend = 0; m_runs = 0; m_prev = 0;
      m_eto = 0; m_eseq = 0; m_ovf = 0;
    end else begin
      if (m_age > 0) begin
        if (int'(bus.state_in) < m_prev) set_seq = 1;
        m_prev = int'(bus.state_in);
        if (bus.abort || bus.done || m_age == TIMEOUT) begin
          if (!bus.abort && bus.done) m_runs = (m_runs + 1) % (1 << RUN_W);
          if (!bus.abort && !bus.done) set_to = 1;
          m_age = 0;
          m_gap = GAP_CYC;
        end else begin
          m_age++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (!bus.abort && (m_pend > 0 || bus.req)) begin
        launch = 1;
        m_age  = 1;
        m_prev = 0;
      end
      if (bus.abort) begin
        m_pend = 0;
      end else begin
        p = m_pend + (bus.req ? 1 : 0) - (launch ? 1 : 0);
        if (p > PMAX) begin
          set_ovf = 1;
          p = PMAX;
        end
        m_pend = p;
      end
      m_eto  = set_to  || (m_eto  && !bus.clr_err);
      m_eseq = set_seq || (m_eseq && !bus.clr_err);
      m_ovf  = set_ovf || (m_ovf  && !bus.clr_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_start",   32'(bus.start),       32'(m_age > 0));
      chk("cyc_busy",    32'(bus.busy),        32'(m_age > 0 || m_gap > 0));
      chk("cyc_pend",    32'(bus.pend_cnt),    32'(m_pend));
      chk("cyc_run_cnt", 32'(bus.run_cnt),     32'(m_runs));
      chk("cyc_err_to",  32'(bus.err_timeout), 32'(m_eto));
      chk("cyc_err_seq", 32'(bus.err_seq),     32'(m_eseq));
      chk("cyc_ovf",     32'(bus.ovf),         32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic pulse_req();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (bus.start && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((bus.busy || bus.pend_cnt != '0) && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(n < bound), 32'd1);
  endtask

  int n_high;
  int rc_save;

  initial begin
    bus.req = 1'b0;
    bus.abort = 1'b0;
    bus.clr_err = 1'b0;
    n_rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_pend",  32'(bus.pend_cnt), 32'd0);
    chk("rst_run",   32'(bus.run_cnt),  32'd0);
    n_rst = 1'b1;
    tick();

    // 1: single run
    pulse_req();
    chk("t1_latency", 32'(bus.start), 32'd1);
    count_high(n_high);
    chk("t1_high_cycles", 32'(n_high), 32'd14);
    chk("t1_gap1_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_gap2_busy", 32'(bus.busy), 32'd1);
    chk("t1_gap2_start", 32'(bus.start), 32'd0);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    chk("t1_run_cnt", 32'(bus.run_cnt), 32'd1);
    chk("t1_pend", 32'(bus.pend_cnt), 32'd0);
    chk("t1_err_seq", 32'(bus.err_seq), 32'd0);

    // 2: queue fill and overflow
    do_reset();
    bus.req = 1'b1;
    repeat (9) tick();
    bus.req = 1'b0;
    chk("t2_pend_full", 32'(bus.pend_cnt), 32'd7);
    chk("t2_ovf", 32'(bus.ovf), 32'd1);
    wait_idle("t2_drain_bound", 600);
    chk("t2_run_cnt", 32'(bus.run_cnt), 32'd8);

    // 3: timeout
    do_reset();
    done_tie0 = 1'b1;
    pulse_req();
    count_high(n_high);
    chk("t3_high_cycles", 32'(n_high), 32'd32);
    chk("t3_err_to", 32'(bus.err_timeout), 32'd1);
    chk("t3_run_cnt", 32'(bus.run_cnt), 32'd0);
    wait_idle("t3_idle_bound", 20);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t3_err_to_clr", 32'(bus.err_timeout), 32'd0);
    done_tie0 = 1'b0;

    // 4: abort on the 5th RUN cycle with 3 queued
    rc_save = int'(bus.run_cnt);
    bus.req = 1'b1;
    repeat (4) tick();
    bus.req = 1'b0;
    chk("t4_pend3", 32'(bus.pend_cnt), 32'd3);
    tick();
    bus.abort = 1'b1;
    chk("t4_run_before", 32'(bus.start), 32'd1);
    tick();
    bus.abort = 1'b0;
    chk("t4_start_low", 32'(bus.start), 32'd0);
    chk("t4_pend0", 32'(bus.pend_cnt), 32'd0);
    chk("t4_run_cnt", 32'(bus.run_cnt), 32'(rc_save));
    chk("t4_flags", {29'd0, bus.err_timeout, bus.err_seq, bus.ovf}, 32'd0);
    chk("t4_gap_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    chk("t4_idle", 32'(bus.busy), 32'd0);
    repeat (5) tick();
    chk("t4_no_launch", 32'(bus.start), 32'd0);

    // 5: backward state step, clr_err in the same cycle
    pulse_req();
    st_ovr_en = 1'b1;
    st_ovr = 2'd0;
    tick();
    st_ovr = 2'd1;
    tick();
    st_ovr = 2'd2;
    tick();
    st_ovr = 2'd1;
    bus.clr_err = 1'b1;
    chk("t5_err_seq_pre", 32'(bus.err_seq), 32'd0);
    tick();
    bus.clr_err = 1'b0;
    st_ovr = 2'd3;
    chk("t5_err_seq_set", 32'(bus.err_seq), 32'd1);
    wait_idle("t5_idle_bound", 40);
    st_ovr_en = 1'b0;
    chk("t5_err_seq_hold", 32'(bus.err_seq), 32'd1);
    chk("t5_run_cnt", 32'(bus.run_cnt), 32'd1);

    // 6: reset mid-run with 2 queued
    bus.req = 1'b1;
    repeat (3) tick();
    bus.req = 1'b0;
    chk("t6_pend2", 32'(bus.pend_cnt), 32'd2);
    chk("t6_running", 32'(bus.start), 32'd1);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("t6_start", 32'(bus.start), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_pend", 32'(bus.pend_cnt), 32'd0);
    chk("t6_run_cnt", 32'(bus.run_cnt), 32'd0);
    chk("t6_flags", {29'd0, bus.err_timeout, bus.err_seq, bus.ovf}, 32'd0);
    n_high = 0;
    repeat (20) begin
      tick();
      if (bus.start) n_high++;
    end
    chk("t6_no_launch", 32'(n_high), 32'd0);

    // 7: run counter wrap
    repeat (257) begin
      pulse_req();
      wait_idle("t7_idle_bound", 40);
    end
    chk("t7_run_wrap", 32'(bus.run_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_launch_ctrl.md
Name: fsm_launch_ctrl

Overview:
Upstream launcher for the 4-phase sequencer (start/done/2-bit state protocol). It queues single-cycle run requests and drives the sequencer's level-sensitive start. It holds start until done or a timeout, then forces a low gap so the sequencer's counter clears. It also checks the sequencer's state progression and keeps run and error counters for software.

Parameters:
PEND_W, 3, pending-request counter width; maximum queued requests = 2^PEND_W-1
TIMEOUT, 32, maximum cycles start stays high without done; legal range 2..2^TMR_W-1
TMR_W, 6, run-timer width
GAP_CYC, 2, cycles start is held low after each run; minimum 1
RUN_W, 8, completed-run counter width

Ports:
clk  input  1  clock, all logic on rising edge
n_rst  input  1  synchronous active-low reset
req  input  1  run request, one per cycle when high
abort  input  1  end the current run and flush all pending requests
clr_err  input  1  clear the sticky error flags
done  input  1  sequencer done, registered level
state_in  input  2  sequencer state_out (0=IDLE, 1=S0, 2=S1, 3=S2)
start  output  1  sequencer start, registered
busy  output  1  high when the FSM is in RUN or GAP
pend_cnt  output  PEND_W  queued requests not yet launched
run_cnt  output  RUN_W  runs completed with done; wraps modulo 2^RUN_W
err_timeout  output  1  sticky: a run ended on timeout
err_seq  output  1  sticky: state_in decreased during a run
ovf  output  1  sticky: a request was dropped because the queue was full

Behaviour:
- Reset (n_rst=0 at a clk edge) sets the FSM to IDLE. All outputs and internal registers go to 0, including the timer, gap counter and prev_state. Reset overrides everything, including mid-run; start is 0 on the following cycle.
- FSM states: IDLE, RUN, GAP. start is registered and is 1 exactly when the FSM is in RUN. busy = (RUN or GAP).
- IDLE -> RUN when (pend_cnt!=0 or req) and abort=0. Launch consumes one request. start goes high on the edge that samples the launching req, so latency from req to start is 1 cycle.
- pend_cnt update each edge: +1 if req is accepted, -1 if a launch occurs, net 0 if both happen.
- req with pend_cnt at its maximum and no launch that cycle: the request is dropped, ovf is set, and pend_cnt is unchanged.
- req is accepted in every state, including while a run is active. Queued requests launch back-to-back, separated only by the gap.
- RUN: tmr clears on entry and increments every RUN cycle. Exit conditions, in priority order:
  1. abort: go to GAP, pend_cnt <= 0, no flags change.
  2. done=1: go to GAP, run_cnt +1.
  3. tmr==TIMEOUT-1 with done=0: go to GAP, err_timeout <= 1. start has then been high for exactly TIMEOUT cycles.
- Paired with the sequencer, a normal run gives done=1 in the 14th cycle of start high. Start falls on the next edge, so start is high for 14 cycles.
- GAP: start=0 for exactly GAP_CYC cycles, then go to IDLE. The next launch therefore occurs at least GAP_CYC+1 cycles after start falls. Any req arriving during GAP is queued.
- abort in IDLE or GAP: pend_cnt <= 0. A req in the same cycle as abort is discarded and does not set ovf.
- Sequence check:
  - prev_state <= 0 on RUN entry, then prev_state <= state_in every RUN cycle.
  - In RUN, if state_in < prev_state, err_seq <= 1.
  - No check is done in IDLE or GAP, because the sequencer legitimately returns to IDLE when start drops.
- clr_err clears err_timeout, err_seq and ovf. If a set event occurs in the same cycle, set wins.
- run_cnt wraps from 2^RUN_W-1 to 0 with no flag.

Test Plan:
1. Single run: one req pulse with the sequencer model attached -> start high on the next edge and stays high 14 cycles. state_in steps 0,1,2,3 with no err_seq. start then low for 2 cycles with busy=1, then busy=0. run_cnt=1, pend_cnt=0.
2. Queue and overflow: 9 consecutive req cycles while IDLE -> the first launches immediately and pend_cnt climbs to 7. The 9th req sets ovf. The remaining 7 runs execute back-to-back with 2-cycle gaps, ending with run_cnt=8.
3. Timeout: done tied to 0 and one req -> start high exactly 32 cycles, err_timeout=1, run_cnt=0. clr_err then clears err_timeout.
4. Abort mid-run: pend_cnt=3 and abort on the 5th RUN cycle -> start low on the next edge, pend_cnt=0, run_cnt unchanged, no flags set, IDLE after GAP_CYC cycles.
5. Sequence error: state_in driven 0,1,2,1 during RUN -> err_seq=1 on the edge after the 1 is sampled. Set-vs-clear priority: clr_err in that same cycle leaves err_seq=1.
6. Reset mid-run: n_rst=0 during RUN with pend_cnt=2 -> on the next edge start=0, pend_cnt=0 and all flags and counters are 0. No launch occurs until a new req.
